// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder: accepts one Gray word, resolves it MSB-first
// one bit per clock, and flags consecutive accepted codes more than one bit apart.
module gray_to_bin_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] g_reg, g_reg_n;
  logic [WIDTH-1:0] bin_reg, bin_n;
  logic [WIDTH-1:0] prev_gray, prev_gray_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             have_prev, have_prev_n;
  logic             err_reg, err_n;
  logic [WIDTH:0]   bin_ext;

  // A zero above the MSB makes the first resolved bit a plain copy of the Gray MSB.
  assign bin_ext = {1'b0, bin_reg};

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n     = state;
    g_reg_n     = g_reg;
    bin_n       = bin_reg;
    prev_gray_n = prev_gray;
    idx_n       = idx;
    have_prev_n = have_prev;
    err_n       = err_reg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          g_reg_n     = gray_in;
          idx_n       = IDX_W'(WIDTH - 1);
          bin_n       = '0;
          err_n       = have_prev && ($countones(gray_in ^ prev_gray) > 1);
          prev_gray_n = gray_in;
          have_prev_n = 1'b1;
          state_n     = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i == int'(idx)) bin_n[i] = g_reg[i] ^ bin_ext[i+1];
        end
        if (idx == '0) state_n = DONE;
        else           idx_n   = idx - IDX_W'(1);
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      g_reg     <= '0;
      bin_reg   <= '0;
      prev_gray <= '0;
      idx       <= '0;
      have_prev <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state     <= state_n;
      g_reg     <= g_reg_n;
      bin_reg   <= bin_n;
      prev_gray <= prev_gray_n;
      idx       <= idx_n;
      have_prev <= have_prev_n;
      err_reg   <= err_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bin_out   = bin_reg;
  assign step_err  = err_reg;

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Directed self-checking bench for gray_to_bin_seq (WIDTH=4).
module tb_gray_to_bin_seq;

  logic       clk;
  logic       rst;
  logic [3:0] gray_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] bin_out;
  logic       step_err;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  gray_to_bin_seq #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin_out  (bin_out),
    .step_err (step_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one word and waits (bounded) for out_valid; completes the transfer if out_ready=1.
  task automatic run_word(input logic [3:0] g, output int lat,
                          output logic [3:0] b, output logic e);
    in_valid = 1'b1;
    gray_in  = g;
    @(posedge clk); #1;
    in_valid = 1'b0;
    gray_in  = ~g;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    b = bin_out;
    e = step_err;
    if (out_ready && lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    gray_in = 4'b1010;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, bin_out, step_err} !== 7'b1_0_0000_0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: rdy=%b vld=%b bin=%b err=%b, want rdy=1 vld=0 bin=0000 err=0",
                 c, in_ready, out_valid, bin_out, step_err);
      end
    end
  endtask

  task automatic test_sequence();
    logic [3:0] codes [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};
    int lat;
    logic [3:0] b;
    logic e;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_word(codes[i], lat, b, e);
      checks++;
      if (lat != 4 || b !== 4'(i) || e !== 1'b0) begin
        errors++;
        $display("FAIL seq[%0d] gray=%b: lat=%0d bin=%b err=%b, want lat=4 bin=%b err=0",
                 i, codes[i], lat, b, e, 4'(i));
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_idle[%0d]: rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_illegal_step();
    int lat;
    logic [3:0] b;
    logic e;
    apply_reset();
    out_ready = 1'b1;
    run_word(4'b0110, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b0100 || e !== 1'b0) begin
      errors++;
      $display("FAIL illegal_first: lat=%0d bin=%b err=%b, want lat=4 bin=0100 err=0", lat, b, e);
    end
    run_word(4'b1101, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b1001 || e !== 1'b1) begin
      errors++;
      $display("FAIL illegal_jump: lat=%0d bin=%b err=%b, want lat=4 bin=1001 err=1", lat, b, e);
    end
    run_word(4'b1101, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b1001 || e !== 1'b0) begin
      errors++;
      $display("FAIL illegal_repeat: lat=%0d bin=%b err=%b, want lat=4 bin=1001 err=0", lat, b, e);
    end
  endtask

  // Previous accepted code is 1101; 1101 -> 1000 is a 2-bit jump.
  task automatic test_back_pressure();
    int lat;
    logic [3:0] b;
    logic e;
    out_ready = 1'b0;
    run_word(4'b1000, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b1111 || e !== 1'b1) begin
      errors++;
      $display("FAIL bp_result: lat=%0d bin=%b err=%b, want lat=4 bin=1111 err=1", lat, b, e);
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      gray_in  = 4'b0111 ^ 4'(i);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bin_out !== 4'b1111 || step_err !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: vld=%b rdy=%b bin=%b err=%b, want vld=1 rdy=0 bin=1111 err=1",
                 i, out_valid, in_ready, bin_out, step_err);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== 4'b1111) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b bin=%b, want vld=0 rdy=1 bin=1111",
               out_valid, in_ready, bin_out);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_single_transfer: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    // Stall-time inputs must not have been taken: 1000 repeated is distance 0.
    run_word(4'b1000, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b1111 || e !== 1'b0) begin
      errors++;
      $display("FAIL bp_prev_kept: lat=%0d bin=%b err=%b, want lat=4 bin=1111 err=0", lat, b, e);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [3:0] b;
    logic e;
    logic seen_valid;
    seen_valid = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    gray_in  = 4'b0111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    seen_valid |= out_valid;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 4'b0000 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: rdy=%b vld=%b bin=%b err=%b, want rdy=1 vld=0 bin=0000 err=0",
               in_ready, out_valid, bin_out, step_err);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen_valid |= out_valid;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result: out_valid seen=%b, want 0", seen_valid);
    end
    run_word(4'b0101, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b0110 || e !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: lat=%0d bin=%b err=%b, want lat=4 bin=0110 err=0", lat, b, e);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [3:0] b;
    logic e;
    apply_reset();
    out_ready = 1'b1;
    run_word(4'b1000, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b1111 || e !== 1'b0) begin
      errors++;
      $display("FAIL wrap_top: lat=%0d bin=%b err=%b, want lat=4 bin=1111 err=0", lat, b, e);
    end
    run_word(4'b0000, lat, b, e);
    checks++;
    if (lat != 4 || b !== 4'b0000 || e !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero: lat=%0d bin=%b err=%b, want lat=4 bin=0000 err=0", lat, b, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    gray_in = '0;
    test_reset();
    test_sequence();
    test_illegal_step();
    test_back_pressure();
    test_reset_mid_op();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_to_bin_seq.md
Name: gray_to_bin_seq

Overview:
Sequential Gray-to-binary decoder, the receive-side counterpart of the 4-bit binary-to-Gray encoder. It accepts one Gray word over a valid/ready handshake and resolves it MSB-first, one bit per clock. It returns the binary word over a second valid/ready handshake. It also flags any pair of consecutive accepted codes that differ in more than one bit, i.e. an illegal Gray step, as used for counter and pointer links.

Parameters:
WIDTH, 4, Gray/binary word width in bits (legal range 2..16)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
gray_in  input  WIDTH  Gray-coded input word
in_valid  input  1  gray_in is valid
in_ready  output  1  block can accept a word this cycle
bin_out  output  WIDTH  decoded binary word
step_err  output  1  current result differs from the previous accepted code in more than 1 bit
out_valid  output  1  bin_out/step_err are valid
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state IDLE; in_ready=1, out_valid=0, bin_out=0, step_err=0;
  - internal shift register, bit index and previous-code register cleared;
  - have_prev=0.
- rst has priority over every other input. rst asserted mid-conversion or in DONE aborts the word; no result is ever presented for it.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 accepts the word: latch gray_in into g_reg, set idx=WIDTH-1, clear bin_out, go to CONV.
  - The same edge computes step_err_next = have_prev and (popcount(gray_in XOR prev_gray) > 1).
  - The same edge then loads prev_gray=gray_in and sets have_prev=1.
- CONV:
  - in_ready=0.
  - Each cycle:
    - bin_out[idx] = g_reg[idx] XOR bin_out[idx+1];
    - for idx=WIDTH-1 the XOR term is 0, so bin_out[MSB] = g_reg[MSB].
  - idx decrements after each cycle.
  - After the cycle that resolves idx=0, go to DONE.
  - Exactly WIDTH cycles are spent in CONV.
- DONE:
  - out_valid=1; bin_out and step_err held stable until the handshake completes.
  - out_valid=1 and out_ready=1 completes the handshake: go to IDLE, out_valid=0.
  - out_ready may be held high continuously.
  - in_ready stays 0 in DONE (no overlap of words).
- Latency: word accepted on edge N; out_valid rises after edge N+WIDTH. Minimum issue interval is WIDTH+2 cycles.
- in_valid=0 while in IDLE: remains IDLE, registers unchanged.
- in_valid is ignored whenever in_ready=0; gray_in changes during CONV or DONE do not affect the result.
- Hamming distance 0 (same code repeated) is legal: step_err=0.
- The first word after reset never flags (have_prev=0).
- Wrap-around is a legal single-bit step, e.g. WIDTH=4, 1000 -> 0000.
- bin_out retains the last result after leaving DONE until the next accept clears it. Only out_valid qualifies it.
- step_err is registered and aligned with the bin_out it belongs to.
- Arithmetic is pure bitwise XOR; no carries; result width equals WIDTH.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 for 5 cycles -> in_ready=1, out_valid=0, bin_out=0000, step_err=0 throughout.
- Exhaustive sequence: feed Gray codes of 0..15 in order (0000, 0001, 0011, 0010, 0110 ... 1000), out_ready=1. Required:
  - bin_out = 0000..1111 in sequence; step_err=0 on every word;
  - out_valid exactly 4 cycles after each accept.
- Illegal step: accept 0110 (bin 0100), then 1101. Required:
  - second result bin_out=1001, step_err=1 (distance 3);
  - then send 1101 again -> step_err=0.
- Back-pressure: accept 1000, hold out_ready=0 for 6 cycles, toggle gray_in and in_valid during the stall. Required:
  - bin_out=1111 stable and out_valid=1 for the whole stall; in_ready=0;
  - release out_ready -> one transfer, then IDLE.
- Reset mid-operation: accept 0111, assert rst in the 2nd CONV cycle. Required:
  - no out_valid pulse;
  - next accept of 0101 gives bin_out=0110 with step_err=0 (have_prev cleared).
- Wrap: accept 1000 then 0000 -> results 1111 then 0000, both step_err=0.
